// File: rtl/sysdef_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sysdef_pkg
//  Description : Shared AES pipeline types: final-round result packet, block
//                and beat geometry, and the output serializer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package sysdef_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BEAT_W  = 32;
    localparam int AES_BEATS   = 4;

    // Width of one buffered result: {en_de, data}
    localparam int AES_ENTRY_W = AES_BLOCK_W + 1;

    // Result leaving the final round; en_de = 1 marks a decrypt result
    typedef struct packed {
        logic                   valid;
        logic [AES_BLOCK_W-1:0] data;
        logic                   en_de;
    } out_packet_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aes_out_fifo
//  Description : Synchronous FIFO with occupancy count. A push on a full FIFO
//                is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_out_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 129
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_out_collector.sv
`default_nettype none
// ============================================================================
//  Module      : aes_out_collector
//  Description : Buffers un-stallable AES round results and serializes each
//                128-bit block into four 32-bit valid/ready beats. Provides an
//                early almost-full stall and a sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_out_collector
    import sysdef_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  out_packet_t             pkt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BEAT_W-1:0]   out_data,
    output logic                    out_last,
    output logic                    out_en_de,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    clr_overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int BEAT_W = $clog2(AES_BEATS);
    localparam logic [CNT_W-1:0]  AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(AES_BEATS - 1);

    collector_state_t   state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               overflow_q, overflow_d;

    logic [AES_ENTRY_W-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   handshake;
    logic                   retire;
    logic                   drop;

    aes_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AES_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pkt_in.valid),
        .push_data_i ({pkt_in.en_de, pkt_in.data}),
        .pop_i       (retire),
        .rd_data_o   (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign handshake = (state_q == STREAM) && out_ready;
    assign retire    = handshake && (beat_q == LAST_BEAT);
    // A full FIFO still takes the push when the head retires this cycle
    assign drop      = pkt_in.valid && fifo_full && !retire;

    assign almost_full = (fifo_count >= AFULL_LVL);
    assign count       = fifo_count;
    assign overflow    = overflow_q;

    // Serializer next state and beat counter; a push into an empty FIFO
    // starts streaming on the very next cycle
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || pkt_in.valid) begin
                    state_d = STREAM;
                    beat_d  = '0;
                end
            end
            STREAM: begin
                if (handshake) begin
                    beat_d = beat_q + 1'b1;
                    if (retire && (fifo_count == CNT_ONE) && !pkt_in.valid)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Sticky overflow; a new drop wins over a simultaneous clear
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    // Output beat selection from the FIFO head, beat 0 being the MSW
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_en_de = 1'b0;
        if (state_q == STREAM) begin
            out_valid = 1'b1;
            out_last  = (beat_q == LAST_BEAT);
            out_en_de = head[AES_BLOCK_W];
            case (beat_q)
                2'd0:    out_data = head[127:96];
                2'd1:    out_data = head[95:64];
                2'd2:    out_data = head[63:32];
                default: out_data = head[31:0];
            endcase
        end
    end

    // State, beat and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_out_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_out_collector
//  Description : Self-checking bench for aes_out_collector using a queue-based
//                reference model, directed scenarios and a random phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_out_collector;
    import sysdef_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFM   = 11;

    logic        clk = 1'b0;
    logic        rst;
    out_packet_t pkt_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_en_de;
    logic        almost_full;
    logic        overflow;
    logic        clr_overflow;
    logic [4:0]  count;

    aes_out_collector #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_in       (pkt_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_en_de    (out_en_de),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of {en_de, data}, current beat index, flag
    logic [128:0] mq[$];
    int           mb   = 0;
    bit           movf = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [128:0] h;
        bit           ne;
        ne = (mq.size() != 0);
        h  = ne ? mq[0] : '0;
        chk("out_valid",   out_valid,   ne);
        chk("out_data",    out_data,    ne ? h[127-32*mb -: 32] : 32'h0);
        chk("out_last",    out_last,    ne && (mb == 3));
        chk("out_en_de",   out_en_de,   ne ? h[128] : 1'b0);
        chk("count",       count,       mq.size());
        chk("almost_full", almost_full, mq.size() >= DEPTH - AFM);
        chk("overflow",    overflow,    movf);
    endtask

    // Check current outputs, then advance one clock and update the model
    task automatic tick();
        bit hs, ret, drop, mv;
        check_model();
        mv   = (mq.size() != 0);
        hs   = mv && out_ready;
        ret  = hs && (mb == 3);
        drop = pkt_in.valid && (mq.size() == DEPTH) && !ret;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mb   = 0;
            movf = 1'b0;
        end else begin
            if (ret) void'(mq.pop_front());
            if (pkt_in.valid && !drop) mq.push_back({pkt_in.en_de, pkt_in.data});
            if (hs) mb = (mb + 1) % 4;
            if (drop) movf = 1'b1;
            else if (clr_overflow) movf = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [127:0] d, input bit e);
        pkt_in.valid = v;
        pkt_in.data  = d;
        pkt_in.en_de = e;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] kat;
    logic [127:0] newblk;
    logic [127:0] lastblk;
    logic [127:0] rblk;
    logic [31:0]  got[4];
    int           nhs;

    initial begin
        kat    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        newblk = 128'hfeedface0123456789abcdef55aa33cc;
        rst = 1'b1;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        drive(1'b0, 128'hdeadbeef, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data,  32'h0);
        chk("rst_count", count,     5'd0);
        chk("rst_ovf",   overflow,  1'b0);

        // Single known-answer block with ready held high
        out_ready = 1'b1;
        drive(1'b1, kat, 1'b0);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("kat_word", out_data, kat[127-32*i -: 32]);
            chk("kat_last", out_last, i == 3);
            chk("kat_ende", out_en_de, 1'b0);
            tick();
        end
        chk("kat_idle", out_valid, 1'b0);

        // Backpressure with ready pattern 1,0,0,1
        drive(1'b1, kat, 1'b1);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        nhs = 0;
        for (int c = 0; c < 40 && nhs < 4; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (out_valid && out_ready) begin
                got[nhs] = out_data;
                nhs++;
            end
            tick();
        end
        chk("bp_handshakes", nhs, 4);
        for (int i = 0; i < 4; i++) chk("bp_word", got[i], kat[127-32*i -: 32]);
        out_ready = 1'b1;
        tick();

        // Filler on invalid cycles is ignored
        for (int i = 0; i < 10; i++) tick();
        chk("filler_count", count,     5'd0);
        chk("filler_valid", out_valid, 1'b0);
        chk("filler_ovf",   overflow,  1'b0);

        // Fill to full with no drain, then one extra block
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, rnd128(), 1'($urandom));
            tick();
            chk("fill_afull", almost_full, i >= 4);
        end
        drive(1'b1, 128'h17171717171717171717171717171717, 1'b1);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        chk("full_ovf",   overflow, 1'b1);
        chk("full_count", count,    5'd16);

        // Clear overflow, then push while the head retires on a full FIFO
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, newblk, 1'b1);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        chk("fr_count", count,    5'd16);
        chk("fr_ovf",   overflow, 1'b0);
        lastblk = '0;
        for (int c = 0; c < 80 && out_valid; c++) begin
            if (out_valid && out_ready) lastblk = {lastblk[95:0], out_data};
            tick();
        end
        chk("drain_done", out_valid, 1'b0);
        chk("fr_lastblk", lastblk,   newblk);

        // Reset in the middle of a block
        rblk = rnd128();
        drive(1'b1, rblk, 1'b1);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", out_valid,   1'b0);
        chk("mrst_data",  out_data,    32'h0);
        chk("mrst_last",  out_last,    1'b0);
        chk("mrst_ende",  out_en_de,   1'b0);
        chk("mrst_afull", almost_full, 1'b0);
        chk("mrst_count", count,       5'd0);
        rblk = rnd128();
        drive(1'b1, rblk, 1'b0);
        tick();
        drive(1'b0, 128'hdeadbeef, 1'b0);
        chk("mrst_beat0", out_data, rblk[127:96]);

        // Random traffic against the model
        for (int c = 0; c < 500; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            out_ready    = ($urandom_range(0, 9) < 6);
            clr_overflow = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 6) drive(1'b1, rnd128(), 1'($urandom));
            else                          drive(1'b0, 128'hdeadbeef, 1'b0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 128'hdeadbeef, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
